// File: rtl/aes.sv
// Fully pipelined AES-128 encryption core: one block per clock, ten round stages, key expanded on the fly.
// Optional macro AES_HOLD_OUTPUT_EN: C keeps the last valid ciphertext while valid is low (otherwise C is 0).
module aes (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] P,
  input  logic [127:0] K,
  output logic [127:0] C,
  output logic         valid
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte n of the state lives at bits [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] key, input logic [7:0] rc);
    logic [31:0] w4, w5, w6, w7;
    w4 = key[127:96] ^ {sbox(key[23:16]), sbox(key[15:8]), sbox(key[7:0]), sbox(key[31:24])}
         ^ {rc, 24'h0};
    w5 = key[95:64] ^ w4;
    w6 = key[63:32] ^ w5;
    w7 = key[31:0]  ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  logic         arm_reg;
  logic [9:0]   v_reg;
  logic [127:0] state_reg [0:9];
  logic [127:0] key_reg   [0:9];
  logic [127:0] key_next  [1:10];
  logic [127:0] round_out [1:10];
  logic [127:0] c_reg;
  logic         valid_reg;

  for (genvar gi = 1; gi <= 10; gi++) begin : g_round
    assign key_next[gi] = key_expand(key_reg[gi-1], RCON[8*(10-gi) +: 8]);
    if (gi < 10) begin : g_full
      assign round_out[gi] = mix_columns(shift_rows(sub_bytes(state_reg[gi-1]))) ^ key_next[gi];
    end else begin : g_last
      assign round_out[gi] = shift_rows(sub_bytes(state_reg[gi-1])) ^ key_next[gi];
    end
  end

  // arm delays the valid chain by one edge so the first post-reset sample is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_reg   <= 1'b0;
      v_reg     <= '0;
      valid_reg <= 1'b0;
      c_reg     <= '0;
      for (int i = 0; i < 10; i++) begin
        state_reg[i] <= '0;
        key_reg[i]   <= '0;
      end
    end else begin
      arm_reg      <= 1'b1;
      v_reg        <= {v_reg[8:0], arm_reg};
      valid_reg    <= v_reg[9];
      state_reg[0] <= P ^ K;
      key_reg[0]   <= K;
      for (int i = 1; i < 10; i++) begin
        state_reg[i] <= round_out[i];
        key_reg[i]   <= key_next[i];
      end
`ifdef AES_HOLD_OUTPUT_EN
      if (v_reg[9]) c_reg <= round_out[10];
`else
      c_reg <= v_reg[9] ? round_out[10] : '0;
`endif
    end
  end

  assign C     = c_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_aes.sv
// Self-checking bench for the aes pipeline: known-answer table, random stream against a
// reference model with a generated S-box, start-up discard and mid-stream reset.
module tb_aes;

  logic         clk;
  logic         rst;
  logic [127:0] P;
  logic [127:0] K;
  logic [127:0] C;
  logic         valid;

  aes dut (.clk(clk), .rst(rst), .P(P), .K(K), .C(C), .valid(valid));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] p;
    logic [127:0] k;
    logic [127:0] c;
  } vec_t;

  vec_t         tbl [3];
  logic [127:0] sb [$];
  logic [7:0]   sbox_t [256];
  int           errors = 0;
  int           checks = 0;
  int           n_edge = 0;
  int           first_valid = 0;
  int           nblk = 0;
  logic [127:0] last_c = '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // S-box derived from first principles: inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, t, b;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(a));
      b = inv;
      t = inv;
      for (int i = 0; i < 4; i++) begin
        t = {t[6:0], t[7]};
        b = b ^ t;
      end
      sbox_t[a] = b ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] p, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n_edge);
    end
  endtask

  function automatic logic [127:0] idle_c();
`ifdef AES_HOLD_OUTPUT_EN
    return last_c;
`else
    return 128'h0;
`endif
  endfunction

  task automatic check_out();
    logic [127:0] e;
    chk("valid", 128'(valid), 128'(n_edge >= 12));
    if (valid) begin
      if (first_valid == 0) first_valid = n_edge;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: valid with no expected block, C=%h", C);
      end else begin
        e = sb.pop_front();
        chk("ciphertext", C, e);
        $display("blk %0d edge %0d C=%h expected %h", nblk, n_edge, C, e);
        nblk++;
        last_c = e;
      end
    end else begin
      chk("idle_C", C, idle_c());
    end
  endtask

  // Wait for the edge-after-negedge, check outputs, then drive the sample for the next edge.
  task automatic cycle(input logic [127:0] p, input logic [127:0] k, input logic [127:0] exp_c);
    @(negedge clk);
    n_edge++;
    check_out();
    P = p;
    K = k;
    sb.push_back(exp_c);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    n_edge = 0;
    first_valid = 0;
  endtask

  logic [127:0] rp, rk;

  initial begin
    tbl[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32};
    tbl[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    build_sbox();

    rst = 1'b1;
    P = '0;
    K = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 128'(valid), 128'h0);
    chk("reset_C", C, 128'h0);

    release_reset();
    P = 'x;
    K = 'x;
    for (int i = 0; i < 3; i++) cycle(tbl[i].p, tbl[i].k, tbl[i].c);
    for (int i = 0; i < 100; i++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      cycle(rp, rk, model(rp, rk));
    end
    for (int i = 0; i < 2; i++) cycle(tbl[2].p, tbl[2].k, tbl[2].c);
    chk("first_valid_edge", 128'(first_valid), 128'd12);

    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_valid", 128'(valid), 128'h0);
    chk("async_rst_C", C, 128'h0);
    sb.delete();
    last_c = '0;
    @(negedge clk);
    chk("in_rst_valid", 128'(valid), 128'h0);
    chk("in_rst_C", C, 128'h0);

    release_reset();
    P = tbl[0].p;
    K = tbl[0].k;
    for (int i = 0; i < 3; i++) cycle(tbl[i].p, tbl[i].k, tbl[i].c);
    for (int i = 0; i < 15; i++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      cycle(rp, rk, model(rp, rk));
    end
    chk("first_valid_after_rst", 128'(first_valid), 128'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
